// File: rtl/instruction_sequencer.sv
// Instruction ROM sequencer: fetches opcode/operand words and issues game actions
// over a valid/ready handshake, with delay, jump and halt support.
module instruction_sequencer #(
   parameter int WIDTH               = 8,
   parameter int INSTRACTION_NUMBERS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [WIDTH-1:0]   curr_command,
   input  logic [2*WIDTH-1:0] in_data,
   output logic               act_valid,
   output logic [2:0]         act_code,
   input  logic               act_ready,
   output logic               busy,
   output logic               done
);

   localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(INSTRACTION_NUMBERS - 1);
   localparam logic [WIDTH-1:0] OP_NOP    = WIDTH'(0);
   localparam logic [WIDTH-1:0] OP_EMIT   = WIDTH'(1);
   localparam logic [WIDTH-1:0] OP_WAIT   = WIDTH'(2);
   localparam logic [WIDTH-1:0] OP_JUMP   = WIDTH'(3);
   localparam logic [WIDTH-1:0] OP_HALT   = WIDTH'(4);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_EMIT,
      S_WAIT
   } state_t;

   state_t               state, state_d;
   logic [WIDTH-1:0]     pc, pc_d;
   logic [2*WIDTH-1:0]   instr, instr_d;
   logic [WIDTH-1:0]     wait_cnt, wait_cnt_d;
   logic                 act_valid_d;
   logic [2:0]           act_code_d;
   logic                 done_d;

   logic [WIDTH-1:0]     opcode;
   logic [WIDTH-1:0]     operand;

   assign opcode       = instr[2*WIDTH-1:WIDTH];
   assign operand      = instr[WIDTH-1:0];
   assign curr_command = pc;
   assign busy         = (state != S_IDLE);

   function automatic logic [WIDTH-1:0] next_pc(input logic [WIDTH-1:0] p);
      return (p == LAST_ADDR) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      // NOTE: every target gets a default first so no path can leave one unassigned and infer a latch.
      state_d     = state;
      pc_d        = pc;
      instr_d     = instr;
      wait_cnt_d  = wait_cnt;
      act_valid_d = act_valid;
      act_code_d  = act_code;
      done_d      = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (start) begin
               pc_d    = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            instr_d = in_data;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            case (opcode)
               OP_EMIT: begin
                  act_code_d  = operand[2:0];
                  act_valid_d = 1'b1;
                  state_d     = S_EMIT;
               end
               OP_WAIT: begin
                  if (operand == '0) begin
                     pc_d    = next_pc(pc);
                     state_d = S_FETCH;
                  end else begin
                     wait_cnt_d = operand;
                     state_d    = S_WAIT;
                  end
               end
               OP_JUMP: begin
                  // Out-of-range targets restart the program rather than address missing ROM.
                  pc_d    = (operand <= LAST_ADDR) ? operand : '0;
                  state_d = S_FETCH;
               end
               OP_HALT: begin
                  done_d  = 1'b1;
                  pc_d    = '0;
                  state_d = S_IDLE;
               end
               default: begin
                  pc_d    = next_pc(pc);
                  state_d = S_FETCH;
               end
            endcase
         end
         S_EMIT: begin
            if (act_ready) begin
               act_valid_d = 1'b0;
               pc_d        = next_pc(pc);
               state_d     = S_FETCH;
            end
         end
         S_WAIT: begin
            if (wait_cnt == WIDTH'(1)) begin
               wait_cnt_d = '0;
               pc_d       = next_pc(pc);
               state_d    = S_FETCH;
            end else begin
               wait_cnt_d = wait_cnt - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         pc        <= '0;
         instr     <= '0;
         wait_cnt  <= '0;
         act_valid <= 1'b0;
         act_code  <= 3'd0;
         done      <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values, matching flop behaviour.
         state     <= state_d;
         pc        <= pc_d;
         instr     <= instr_d;
         wait_cnt  <= wait_cnt_d;
         act_valid <= act_valid_d;
         act_code  <= act_code_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: small combinational ROM model and
// hand-computed cycle-by-cycle expectations per scenario.
module tb_instruction_sequencer;

   localparam int W = 8;

   logic           clk       = 1'b0;
   logic           rst       = 1'b1;
   logic           start     = 1'b0;
   logic           act_ready = 1'b0;
   logic [W-1:0]   curr_command;
   logic [2*W-1:0] in_data;
   logic           act_valid;
   logic [2:0]     act_code;
   logic           busy;
   logic           done;

   logic [2*W-1:0] rom [4];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign in_data = (curr_command < 8'd4) ? rom[curr_command[1:0]] : '0;

   instruction_sequencer #(.WIDTH(W), .INSTRACTION_NUMBERS(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .curr_command (curr_command),
      .in_data      (in_data),
      .act_valid    (act_valid),
      .act_code     (act_code),
      .act_ready    (act_ready),
      .busy         (busy),
      .done         (done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load_rom(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
      rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      total++;
      if ({curr_command, act_valid, act_code, busy, done} !== 14'd0) begin
         bad++;
         $display("FAIL reset_async: got %h want 0", {curr_command, act_valid, act_code, busy, done});
      end
      tick();
      total++;
      if ({curr_command, act_valid, act_code, busy, done} !== 14'd0) begin
         bad++;
         $display("FAIL reset_held: got %h want 0", {curr_command, act_valid, act_code, busy, done});
      end
      rst = 1'b1;
   endtask

   task automatic test_emit_halt();
      load_rom(16'h0101, 16'h0405, 16'h0000, 16'h0000);
      act_ready = 1'b1;
      pulse_start();
      total++;
      if ({busy, act_valid, curr_command} !== {1'b1, 1'b0, 8'd0}) begin
         bad++;
         $display("FAIL emit_start: got busy=%b valid=%b pc=%0d want 1 0 0", busy, act_valid, curr_command);
      end
      tick(); tick();
      total++;
      if ({act_valid, act_code, curr_command} !== {1'b1, 3'd1, 8'd0}) begin
         bad++;
         $display("FAIL emit_offer: got valid=%b code=%0d pc=%0d want 1 1 0", act_valid, act_code, curr_command);
      end
      tick();
      total++;
      if ({act_valid, curr_command} !== {1'b0, 8'd1}) begin
         bad++;
         $display("FAIL emit_accept: got valid=%b pc=%0d want 0 1", act_valid, curr_command);
      end
      tick();
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL emit_early_done: got %b want 0", done);
      end
      tick();
      total++;
      if ({done, busy, curr_command} !== {1'b1, 1'b0, 8'd0}) begin
         bad++;
         $display("FAIL emit_halt: got done=%b busy=%b pc=%0d want 1 0 0", done, busy, curr_command);
      end
      tick();
      total++;
      if ({done, busy} !== 2'b00) begin
         bad++;
         $display("FAIL emit_done_pulse: got done=%b busy=%b want 0 0", done, busy);
      end
      act_ready = 1'b0;
   endtask

   task automatic test_emit_stall();
      load_rom(16'h0103, 16'h0400, 16'h0000, 16'h0000);
      act_ready = 1'b0;
      pulse_start();
      tick(); tick();
      for (int i = 0; i < 6; i++) begin
         start = (i == 2);
         tick();
         start = 1'b0;
         total++;
         if ({act_valid, act_code, busy, curr_command} !== {1'b1, 3'd3, 1'b1, 8'd0}) begin
            bad++;
            $display("FAIL stall_hold[%0d]: got valid=%b code=%0d busy=%b pc=%0d want 1 3 1 0",
                     i, act_valid, act_code, busy, curr_command);
         end
      end
      act_ready = 1'b1;
      tick();
      act_ready = 1'b0;
      total++;
      if ({act_valid, curr_command} !== {1'b0, 8'd1}) begin
         bad++;
         $display("FAIL stall_accept: got valid=%b pc=%0d want 0 1", act_valid, curr_command);
      end
      tick(); tick();
      total++;
      if ({done, busy} !== 2'b10) begin
         bad++;
         $display("FAIL stall_halt: got done=%b busy=%b want 1 0", done, busy);
      end
   endtask

   task automatic test_wait();
      logic [7:0] exp_pc   [7] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0};
      logic       exp_done [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      load_rom(16'h0203, 16'h0400, 16'h0000, 16'h0000);
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         tick();
         total++;
         if ({curr_command, done, busy} !== {exp_pc[i], exp_done[i], ~exp_done[i]}) begin
            bad++;
            $display("FAIL wait_cycle[%0d]: got pc=%0d done=%b busy=%b want %0d %b %b",
                     i + 1, curr_command, done, busy, exp_pc[i], exp_done[i], ~exp_done[i]);
         end
      end
   endtask

   task automatic test_jump_loop();
      logic [7:0] exp_pc [7] = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd1};
      load_rom(16'h0000, 16'h0302, 16'h0000, 16'h0301);
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         tick(); tick();
         total++;
         if ({curr_command, busy, done} !== {exp_pc[i], 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL loop_pc[%0d]: got pc=%0d busy=%b done=%b want %0d 1 0",
                     i, curr_command, busy, done, exp_pc[i]);
         end
      end
      apply_reset();
   endtask

   task automatic test_jump_oob();
      logic [7:0] exp_pc [3] = '{8'd1, 8'd0, 8'd1};
      load_rom(16'h0000, 16'h0309, 16'h0000, 16'h0000);
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         tick(); tick();
         total++;
         if (curr_command !== exp_pc[i]) begin
            bad++;
            $display("FAIL jump_oob[%0d]: got pc=%0d want %0d", i, curr_command, exp_pc[i]);
         end
      end
      apply_reset();
   endtask

   task automatic test_wrap();
      logic [7:0] exp_pc [5] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
      load_rom(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         tick(); tick();
         total++;
         if (curr_command !== exp_pc[i]) begin
            bad++;
            $display("FAIL wrap_pc[%0d]: got pc=%0d want %0d", i, curr_command, exp_pc[i]);
         end
      end
      apply_reset();
   endtask

   task automatic test_reset_mid();
      load_rom(16'h0000, 16'h0105, 16'h0400, 16'h0000);
      act_ready = 1'b0;
      pulse_start();
      tick(); tick(); tick(); tick();
      total++;
      if ({act_valid, act_code, curr_command} !== {1'b1, 3'd5, 8'd1}) begin
         bad++;
         $display("FAIL mid_pre: got valid=%b code=%0d pc=%0d want 1 5 1", act_valid, act_code, curr_command);
      end
      #2 rst = 1'b0;
      #1;
      total++;
      if ({act_valid, act_code, busy, curr_command} !== {1'b0, 3'd0, 1'b0, 8'd0}) begin
         bad++;
         $display("FAIL mid_async_clear: got valid=%b code=%0d busy=%b pc=%0d want 0 0 0 0",
                  act_valid, act_code, busy, curr_command);
      end
      tick();
      rst = 1'b1;
      pulse_start();
      total++;
      if ({busy, curr_command} !== {1'b1, 8'd0}) begin
         bad++;
         $display("FAIL mid_restart: got busy=%b pc=%0d want 1 0", busy, curr_command);
      end
      tick(); tick(); tick(); tick();
      total++;
      if ({act_valid, act_code, curr_command} !== {1'b1, 3'd5, 8'd1}) begin
         bad++;
         $display("FAIL mid_reemit: got valid=%b code=%0d pc=%0d want 1 5 1", act_valid, act_code, curr_command);
      end
      act_ready = 1'b1;
      tick();
      act_ready = 1'b0;
      tick(); tick();
      total++;
      if ({done, busy} !== 2'b10) begin
         bad++;
         $display("FAIL mid_halt: got done=%b busy=%b want 1 0", done, busy);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      load_rom(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      test_reset();
      test_emit_halt();
      test_emit_stall();
      test_wait();
      test_jump_loop();
      test_jump_oob();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Read-side master of the instruction ROM; owns the program counter.
- Drives `curr_command` (ROM address) and consumes the combinational `out_data` word.
- Decodes each word and issues game actions (move/rotate/drop codes) to the tetris game logic over a valid/ready handshake.
- Supports delays, jumps and halt, so a stored list can script piece behaviour.

Parameters:
- WIDTH, 8, opcode/operand width; ROM address width.
- INSTRACTION_NUMBERS, 4, number of ROM words; valid addresses are 0..INSTRACTION_NUMBERS-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins execution at address 0 when idle.
- curr_command  output  WIDTH  ROM address; always equals the pc register.
- in_data  input  2*WIDTH  ROM word. [2W-1:W] is the opcode; [W-1:0] is the operand.
- act_valid  output  1  action offered to the game.
- act_code  output  3  action code, equal to operand[2:0].
- act_ready  input  1  game accepts the action.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on HALT.

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=0, instr=0, wait_cnt=0, act_valid=0, act_code=0, busy=0, done=0.
- States: IDLE, FETCH, EXEC, EMIT, WAIT.
- IDLE: start=1 -> pc<=0, go to FETCH. Otherwise stay.
- FETCH: instr<=in_data (ROM read is combinational from curr_command), go to EXEC. One cycle.
- EXEC: decode opcode = instr[2W-1:W].
  - 0x00 NOP, and any undefined opcode: pc<=next(pc), go to FETCH.
  - 0x01 EMIT: act_code<=operand[2:0], act_valid<=1, go to EMIT.
  - 0x02 WAIT:
    - operand=0: behaves as NOP.
    - else: wait_cnt<=operand, go to WAIT.
  - 0x03 JUMP:
    - operand < INSTRACTION_NUMBERS: pc<=operand.
    - else: pc<=0.
    - Then go to FETCH.
  - 0x04 HALT: done<=1 for one cycle, pc<=0, go to IDLE.
- next(pc): pc+1, wrapping to 0 when pc = INSTRACTION_NUMBERS-1.
- EMIT:
  - act_valid and act_code hold stable until a cycle with act_ready=1.
  - On that edge: act_valid<=0, pc<=next(pc), go to FETCH.
  - act_ready while act_valid=0 is ignored.
- WAIT:
  - wait_cnt decrements each cycle.
  - When wait_cnt=1: pc<=next(pc), go to FETCH.
  - Time in WAIT is exactly operand cycles.
- Latency per instruction:
  - NOP/JUMP: 2 cycles.
  - WAIT n: 2+n cycles.
  - EMIT: 2 + cycles until act_ready (minimum 3 with act_ready tied high).
  - HALT: 2 cycles, then done.
- start while busy is ignored.
- Reset mid-operation: immediate return to reset values; any pending action is dropped (act_valid falls asynchronously).
- The ROM word is sampled only in FETCH; in_data changes at other times have no effect.

Test Plan:
- ROM {0x0101, 0x0405}, start pulse -> curr_command 0 then 1. act_valid=1 with act_code=1 appears 2 cycles after start. With act_ready=1, done pulses at cycle 5. busy falls with done.
- ROM {0x0103, 0x0400}, act_ready held 0 for 6 cycles then 1 -> act_valid/act_code=3 held stable all 6 cycles. Acceptance occurs on the first ready edge, followed by HALT.
- ROM {0x0203, 0x0400} -> WAIT occupies exactly 3 cycles. done asserted 7 cycles after start.
- ROM {0x0000, 0x0302, 0x0000, 0x0301} -> pc sequence 0,1,2,3,1,2,3,... Never halts; busy stays 1.
- ROM {0x0309, ...} (jump target ≥ 4) -> pc<=0. ROM {0x0000, 0x0000, 0x0000, 0x0000} -> pc wraps 3->0.
- rst=0 asserted while act_valid=1 in EMIT -> act_valid, busy and pc=0 all clear without waiting for a clock edge. A start pulse then restarts from address 0.
